mips_mem_responder: RTL and testbench
=====================================

// Module: mips_mem_responder
// PURPOSE
//  Memory-side responder for the single-clock mips core. Answers the core's
//  instruction fetch (pc -> instr) and data port (aluout/writedata/memwrite ->
//  readdata). Holds the core in reset while a host streams a program into
//  instruction memory, releases it, and freezes it on a HALT opcode.
// PARAMETERS
//  IADDR_W  8   instruction address width; imem depth = 2**IADDR_W words x 16b
//  DADDR_W  8   data address width; dmem depth = 2**DADDR_W words x 16b
// PORTS
//  clk         in   1   system clock, all state on rising edge
//  reset       in   1   synchronous, active-high; restarts program load
//  load_valid  in   1   host word valid
//  load_data   in   16  host instruction word
//  load_last   in   1   marks final program word (qualified by load_valid)
//  load_ready  out  1   responder accepts a load word this cycle
//  cpu_reset   out  1   registered; drives mips.reset
//  pc          in   8   mips fetch address (low IADDR_W bits used)
//  instr       out  16  instruction to mips (combinational)
//  memwrite    in   1   mips store strobe
//  aluout      in   16  mips data address (low DADDR_W bits used)
//  writedata   in   16  mips store data
//  readdata    out  16  load data to mips (combinational)
//  halted      out  1   registered; HALT retired
// BEHAVIOUR
//  - States: LOAD, RUN, HALTED. Reset -> LOAD, ptr=0, count=0, cpu_reset=1,
//    halted=0. Memory arrays are not cleared by reset.
//  - LOAD: load_ready=1. Accept = load_valid & load_ready: imem[ptr]<=load_data,
//    ptr++, count++ (count is IADDR_W+1 bits, max 2**IADDR_W). If accepted
//    word has load_last=1 or count reaches 2**IADDR_W -> RUN next cycle;
//    cpu_reset falls on the same edge that enters RUN. instr=NOP (16'h0800).
//  - RUN: load_ready=0, load_valid ignored. instr = imem[pc] if pc<count,
//    else NOP 16'h0800 (stale words past count never leak).
//    readdata = dmem[aluout[DADDR_W-1:0]] always (combinational, async read).
//    Store: memwrite=1 -> dmem[addr]<=writedata on clk edge; read-during-write
//    of same address returns OLD data in that cycle.
//  - HALT: in RUN, instr[15:11]==5'b11011 -> HALTED on next edge, halted=1.
//  - HALTED: instr forced to 16'hD800 (HALT), memwrite ignored (dmem frozen),
//    readdata still served, cpu_reset=0. Exit only via reset.
//  - Zero-length program impossible: first accepted word always counts.
//  - Reset mid-load or mid-run: back to LOAD, count=0, halted=0, cpu_reset=1
//    on next edge; dmem contents preserved.
//  - memwrite while in LOAD ignored.
// CONFIGURATION
//  MEM_STORE_CNT_EN defined: adds output port store_cnt [15:0]; counts
//    accepted stores in RUN, saturates at 16'hFFFF, cleared by reset.
//  Not defined: port absent, no counter logic.
// TESTING
//  1 reset, stream 3 words (last on 3rd) -> load_ready 1,1,1 then 0; cpu_reset
//    falls the cycle after 3rd accept; pc=0..2 return the words, pc=3 -> 16'h0800.
//  2 load_valid low for 4 cycles mid-stream -> ptr/count hold, no spurious write.
//  3 RUN: memwrite=1 aluout=16'h0002 writedata=16'h1234 -> same-cycle readdata
//    old value; next cycle aluout=2 gives 16'h1234; aluout=16'hFF02 aliases to 2.
//  4 pc fetches 16'hD800 -> halted=1 next cycle, instr=16'hD800 for any pc,
//    memwrite=1 to addr 5 leaves dmem[5] unchanged.
//  5 reset while HALTED -> halted=0, cpu_reset=1, load_ready=1, count=0,
//    dmem[2] still 16'h1234; reload 1 word, pc=1 returns 16'h0800.
//  6 load 256 words without load_last -> RUN after 256th accept, pc=255 valid.
//    (MEM_STORE_CNT_EN: 3 stores -> store_cnt=3; stores in HALTED not counted.)

Source files
------------

// File: rtl/mips_mem_responder.sv
// Memory-side responder for the mips core: program loader, instruction/data memories, halt freeze.
// Optional MEM_STORE_CNT_EN adds a saturating store counter output (store_cnt).
module mips_mem_responder #(
  parameter int IADDR_W = 8,
  parameter int DADDR_W = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_valid,
  input  logic [15:0] load_data,
  input  logic        load_last,
  output logic        load_ready,
  output logic        cpu_reset,
  input  logic [7:0]  pc,
  output logic [15:0] instr,
  input  logic        memwrite,
  input  logic [15:0] aluout,
  input  logic [15:0] writedata,
  output logic [15:0] readdata,
`ifdef MEM_STORE_CNT_EN
  output logic [15:0] store_cnt,
`endif
  output logic        halted
);
  localparam logic [15:0] NOP    = 16'h0800;
  localparam logic [15:0] HALT_W = 16'hD800;
  localparam logic [IADDR_W:0] LAST_CNT = (IADDR_W+1)'((2**IADDR_W) - 1);

  typedef enum logic [1:0] {S_LOAD, S_RUN, S_HALTED} state_t;
  state_t state, state_n;

  logic [15:0]        imem [2**IADDR_W];
  logic [15:0]        dmem [2**DADDR_W];
  logic [IADDR_W-1:0] ptr;
  logic [IADDR_W:0]   count;
  logic               accept, store;
  logic [IADDR_W-1:0] pidx;
  logic [DADDR_W-1:0] daddr;
  logic               unused_hi;

  assign pidx      = IADDR_W'(pc);
  assign daddr     = aluout[DADDR_W-1:0];
  assign unused_hi = ^aluout[15:DADDR_W];
  assign accept    = load_valid & load_ready;
  assign store     = memwrite & (state == S_RUN);

  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= S_LOAD;
    else       state <= state_n;
  end

  // next state
  always_comb begin
    state_n = state;
    case (state)
      S_LOAD:   if (accept && (load_last || count == LAST_CNT)) state_n = S_RUN;
      S_RUN:    if (instr[15:11] == 5'b11011) state_n = S_HALTED;
      S_HALTED: state_n = S_HALTED;
      default:  state_n = S_LOAD;
    endcase
  end

  // outputs; words past the loaded count read as NOP so stale imem never leaks
  always_comb begin
    load_ready = (state == S_LOAD);
    readdata   = dmem[daddr];
    instr      = NOP;
    case (state)
      S_RUN:    if ({1'b0, pidx} < count) instr = imem[pidx];
      S_HALTED: instr = HALT_W;
      default:  instr = NOP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr       <= '0;
      count     <= '0;
      cpu_reset <= 1'b1;
      halted    <= 1'b0;
    end else begin
      if (accept) begin
        ptr   <= ptr + 1'b1;
        count <= count + 1'b1;
      end
      cpu_reset <= (state_n == S_LOAD);
      halted    <= (state_n == S_HALTED);
    end
  end

  // arrays survive reset
  always_ff @(posedge clk) begin
    if (!reset && accept) imem[ptr] <= load_data;
    if (store)            dmem[daddr] <= writedata;
  end

`ifdef MEM_STORE_CNT_EN
  always_ff @(posedge clk) begin
    if (reset)                            store_cnt <= '0;
    else if (store && store_cnt != 16'hFFFF) store_cnt <= store_cnt + 16'd1;
  end
`endif
endmodule

// File: tb/tb_mips_mem_responder.sv
// Directed bench for mips_mem_responder: load, run, store, halt, reset and full-depth load.
module tb_mips_mem_responder;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        load_valid = 1'b0;
  logic [15:0] load_data = '0;
  logic        load_last = 1'b0;
  logic        load_ready, cpu_reset, halted;
  logic [7:0]  pc = '0;
  logic [15:0] instr, readdata;
  logic        memwrite = 1'b0;
  logic [15:0] aluout = '0;
  logic [15:0] writedata = '0;
`ifdef MEM_STORE_CNT_EN
  logic [15:0] store_cnt;
`endif
  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mips_mem_responder dut (
    .clk(clk), .reset(reset),
    .load_valid(load_valid), .load_data(load_data), .load_last(load_last),
    .load_ready(load_ready), .cpu_reset(cpu_reset),
    .pc(pc), .instr(instr),
    .memwrite(memwrite), .aluout(aluout), .writedata(writedata), .readdata(readdata),
`ifdef MEM_STORE_CNT_EN
    .store_cnt(store_cnt),
`endif
    .halted(halted)
  );

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; tick(); tick(); reset = 1'b0; #1;
    n_chk++; if ({load_ready, cpu_reset, halted} !== 3'b110) begin
      n_fail++; $display("FAIL reset_flags got %b want 110", {load_ready, cpu_reset, halted}); end
    n_chk++; if (instr !== 16'h0800) begin
      n_fail++; $display("FAIL reset_instr got %h want 0800", instr); end
  endtask

  // three words with a 4-cycle load_valid gap before the last
  task automatic test_load_gap();
    logic [15:0] w [3];
    int bad = 0;
    w[0] = 16'h1111; w[1] = 16'h2222; w[2] = 16'hD800;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) begin
        load_valid = 1'b0;
        for (int g = 0; g < 4; g++) begin
          tick();
          if (load_ready !== 1'b1 || cpu_reset !== 1'b1) bad++;
        end
      end
      load_valid = 1'b1; load_data = w[i]; load_last = (i == 2); #1;
      if (load_ready !== 1'b1) bad++;
      tick();
    end
    load_valid = 1'b0; load_last = 1'b0; #1;
    n_chk++; if (bad != 0) begin
      n_fail++; $display("FAIL load_ready_during_load got %0d bad cycles want 0", bad); end
    n_chk++; if ({load_ready, cpu_reset} !== 2'b00) begin
      n_fail++; $display("FAIL enter_run got ready,cpu_reset=%b want 00", {load_ready, cpu_reset}); end
    for (int i = 0; i < 4; i++) begin
      pc = 8'(i); #1;
      n_chk++; if (instr !== ((i < 3) ? w[i] : 16'h0800)) begin
        n_fail++; $display("FAIL fetch_pc%0d got %h want %h", i, instr, (i < 3) ? w[i] : 16'h0800); end
    end
  endtask

  task automatic test_store();
    memwrite = 1'b1; aluout = 16'h0002; writedata = 16'hAAAA; tick();
    aluout = 16'h0005; writedata = 16'h5555; tick();
    aluout = 16'h0002; writedata = 16'h1234; #1;
    n_chk++; if (readdata !== 16'hAAAA) begin
      n_fail++; $display("FAIL rdw_old got %h want aaaa", readdata); end
    tick(); memwrite = 1'b0; #1;
    n_chk++; if (readdata !== 16'h1234) begin
      n_fail++; $display("FAIL store_read got %h want 1234", readdata); end
    aluout = 16'hFF02; #1;
    n_chk++; if (readdata !== 16'h1234) begin
      n_fail++; $display("FAIL alias_ff02 got %h want 1234", readdata); end
  endtask

  task automatic test_halt();
    pc = 8'd2; #1;
    n_chk++; if (instr !== 16'hD800 || halted !== 1'b0) begin
      n_fail++; $display("FAIL pre_halt got instr=%h halted=%b want d800 0", instr, halted); end
    tick(); pc = 8'd0; #1;
    n_chk++; if (halted !== 1'b1 || instr !== 16'hD800) begin
      n_fail++; $display("FAIL halted got halted=%b instr=%h want 1 d800", halted, instr); end
    pc = 8'd7; #1;
    n_chk++; if (instr !== 16'hD800) begin
      n_fail++; $display("FAIL halted_pc7 got %h want d800", instr); end
    memwrite = 1'b1; aluout = 16'h0005; writedata = 16'hFFFF; tick(); tick();
    memwrite = 1'b0; #1;
    n_chk++; if (readdata !== 16'h5555 || cpu_reset !== 1'b0) begin
      n_fail++; $display("FAIL frozen_dmem got %h cpu_reset=%b want 5555 0", readdata, cpu_reset); end
`ifdef MEM_STORE_CNT_EN
    n_chk++; if (store_cnt !== 16'd3) begin
      n_fail++; $display("FAIL store_cnt got %0d want 3", store_cnt); end
`endif
  endtask

  task automatic test_reset_halted();
    reset = 1'b1; tick(); reset = 1'b0; aluout = 16'h0002; pc = 8'd1; #1;
    n_chk++; if ({load_ready, cpu_reset, halted} !== 3'b110) begin
      n_fail++; $display("FAIL rst_halt_flags got %b want 110", {load_ready, cpu_reset, halted}); end
    n_chk++; if (readdata !== 16'h1234) begin
      n_fail++; $display("FAIL dmem_kept got %h want 1234", readdata); end
`ifdef MEM_STORE_CNT_EN
    n_chk++; if (store_cnt !== 16'd0) begin
      n_fail++; $display("FAIL store_cnt_clr got %0d want 0", store_cnt); end
`endif
    load_valid = 1'b1; load_data = 16'h4444; load_last = 1'b1; tick();
    load_valid = 1'b0; load_last = 1'b0; #1;
    n_chk++; if (instr !== 16'h0800 || cpu_reset !== 1'b0) begin
      n_fail++; $display("FAIL stale_pc1 got %h cpu_reset=%b want 0800 0", instr, cpu_reset); end
    pc = 8'd0; #1;
    n_chk++; if (instr !== 16'h4444) begin
      n_fail++; $display("FAIL reload_pc0 got %h want 4444", instr); end
  endtask

  task automatic test_full_load();
    reset = 1'b1; tick(); reset = 1'b0;
    load_valid = 1'b1;
    for (int i = 0; i < 256; i++) begin
      load_data = {8'h10, 8'(i)};
      if (i == 255) begin
        #1;
        n_chk++; if (load_ready !== 1'b1 || cpu_reset !== 1'b1) begin
          n_fail++; $display("FAIL before_256 got ready=%b cpu_reset=%b want 1 1", load_ready, cpu_reset); end
      end
      tick();
    end
    load_valid = 1'b0; #1;
    n_chk++; if ({load_ready, cpu_reset} !== 2'b00) begin
      n_fail++; $display("FAIL full_run got %b want 00", {load_ready, cpu_reset}); end
    pc = 8'd255; #1;
    n_chk++; if (instr !== 16'h10FF) begin
      n_fail++; $display("FAIL full_pc255 got %h want 10ff", instr); end
    pc = 8'd128; #1;
    n_chk++; if (instr !== 16'h1080) begin
      n_fail++; $display("FAIL full_pc128 got %h want 1080", instr); end
  endtask

  initial begin
    test_reset();
    test_load_gap();
    test_store();
    test_halt();
    test_reset_halted();
    test_full_load();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
